// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter sequencing N_REQ requesters onto one shared GCD unit
module gcd_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   gcd_start,
  output logic [WIDTH-1:0]       gcd_data,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_result
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [IW-1:0] ptr, idx, win, lo, hi;
  logic hit, byp, timeout;
  logic [WIDTH-1:0] a_q, b_q, a_sel, b_sel;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] onehot;
  always_comb begin
    lo = '0;
    hi = '0;
    hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) lo = IW'(i);
      if (req[i] && IW'(i) >= ptr) begin
        hi = IW'(i);
        hit = 1'b1;
      end
    end
    win = hit ? hi : lo;
  end
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == win) begin
        a_sel = op_a[i*WIDTH +: WIDTH];
        b_sel = op_b[i*WIDTH +: WIDTH];
      end
    end
  end
  assign timeout = cnt == CW'(MAX_WAIT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |req ? ((a_sel != '0 && b_sel != '0) ? LOAD_A : RESP) : IDLE;
      LOAD_A:  nxt = LOAD_B;
      LOAD_B:  nxt = WAIT;
      WAIT:    nxt = (gcd_done || timeout) ? RESP : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      byp <= 1'b0;
      cnt <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          idx <= win;
          a_q <= a_sel;
          b_q <= b_sel;
          byp <= a_sel == '0 || b_sel == '0;
          if (a_sel == '0 || b_sel == '0) begin
            resp_data <= a_sel == '0 ? b_sel : a_sel;
            resp_err <= a_sel == '0 && b_sel == '0;
          end
        end
        LOAD_B: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (gcd_done) begin
            resp_data <= gcd_result;
            resp_err <= 1'b0;
          end else if (timeout) begin
            resp_data <= '0;
            resp_err <= 1'b1;
          end
        end
        RESP: ptr <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end
  always_comb begin
    onehot = N_REQ'(1) << idx;
    gnt = (state == LOAD_A || (state == RESP && byp)) ? onehot : '0;
    resp_valid = state == RESP ? onehot : '0;
    busy = state != IDLE;
    gcd_start = state == LOAD_A;
    gcd_data = state == LOAD_A ? a_q : (state == LOAD_B || state == WAIT) ? b_q : '0;
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and random checks of gcd_arbiter against a behavioural arbitration/GCD model
module tb_gcd_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int MW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] op_a = '0;
  logic [N*W-1:0] op_b = '0;
  logic [N-1:0] gnt, resp_valid;
  logic [W-1:0] resp_data, gcd_data;
  logic resp_err, busy, gcd_start;
  logic gcd_done = 1'b0;
  logic [W-1:0] gcd_result = '0;
  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .gcd_start(gcd_start), .gcd_data(gcd_data),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ma[i] = a;
    mb[i] = b;
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, gcd_start, 0);
    chk({tag, "_gdata"}, gcd_data, 0);
  endtask
  // Called at a falling edge while the DUT idles with req != 0; done_at is the WAIT cycle (1-based) raising done, out of range = never.
  task automatic serve(input int done_at, input bit spur);
    int w, last;
    logic [W-1:0] a, b, ga, gb, exp_d;
    logic exp_e;
    w = -1;
    for (int o = 0; o < N; o++)
      if (w < 0 && req[(ptr_m + o) % N]) w = (ptr_m + o) % N;
    a = ma[w];
    b = mb[w];
    @(negedge clk);
    if (a == 0 || b == 0) begin
      exp_d = a == 0 ? b : a;
      exp_e = a == 0 && b == 0;
      chk("byp_gnt", gnt, 1 << w);
      chk("byp_valid", resp_valid, 1 << w);
      chk("byp_data", resp_data, exp_d);
      chk("byp_err", resp_err, exp_e);
      chk("byp_start", gcd_start, 0);
      req[w] = 1'b0;
    end else begin
      chk("c1_gnt", gnt, 1 << w);
      chk("c1_start", gcd_start, 1);
      chk("c1_data", gcd_data, a);
      chk("c1_valid", resp_valid, 0);
      ga = gcd_data;
      req[w] = 1'b0;
      @(negedge clk);
      chk("c2_gnt", gnt, 0);
      chk("c2_start", gcd_start, 0);
      chk("c2_data", gcd_data, b);
      gb = gcd_data;
      if (spur) begin
        gcd_done = 1'b1;
        gcd_result = 16'hdead;
      end
      last = (done_at >= 1 && done_at <= MW) ? done_at : MW;
      for (int k = 1; k <= last; k++) begin
        @(negedge clk);
        gcd_done = 1'b0;
        chk("wait_busy", busy, 1);
        chk("wait_valid", resp_valid, 0);
        chk("wait_data", gcd_data, b);
        if (k == done_at) begin
          gcd_done = 1'b1;
          gcd_result = gcd_ref(ga, gb);
        end
      end
      exp_d = (done_at >= 1 && done_at <= MW) ? gcd_ref(a, b) : '0;
      exp_e = !(done_at >= 1 && done_at <= MW);
      @(negedge clk);
      gcd_done = 1'b0;
      chk("resp_valid", resp_valid, 1 << w);
      chk("resp_data", resp_data, exp_d);
      chk("resp_err", resp_err, exp_e);
      chk("resp_gnt", gnt, 0);
    end
    ptr_m = (w + 1) % N;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", resp_valid, 0);
    chk("idle_start", gcd_start, 0);
    chk("hold_data", resp_data, exp_d);
    chk("hold_err", resp_err, exp_e);
  endtask
  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_op(0, 12, 18);
    set_op(1, 0, 7);
    set_op(2, 45, 30);
    set_op(3, 0, 0);
    req = 4'b1111;
    for (int i = 0; i < N; i++) serve(2, 0);
    set_op(0, 20, 0);
    set_op(2, 49, 21);
    req = 4'b0101;
    serve(1, 0);
    serve(1, 0);
    set_op(0, 36, 24);
    req = 4'b0001;
    serve(6, 0);
    set_op(1, 0, 15);
    req = 4'b0010;
    serve(0, 0);
    set_op(2, 9, 0);
    req = 4'b0100;
    serve(0, 0);
    set_op(3, 0, 0);
    req = 4'b1000;
    serve(0, 0);
    set_op(1, 30, 12);
    req = 4'b0010;
    serve(0, 0);
    req = 4'b0010;
    serve(MW, 0);
    gcd_done = 1'b1;
    gcd_result = 16'h0005;
    @(negedge clk);
    gcd_done = 1'b0;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_valid", resp_valid, 0);
    set_op(2, 1000, 250);
    req = 4'b0100;
    serve(3, 1);
    for (int it = 0; it < 40; it++) begin
      if (req == 0 || $urandom_range(0, 1) == 1) begin
        logic [N-1:0] m;
        m = N'($urandom_range(1, 15));
        for (int i = 0; i < N; i++) begin
          if (m[i] && !req[i]) begin
            logic [W-1:0] g;
            g = W'($urandom_range(1, 60));
            set_op(i, ($urandom_range(0, 4) == 0) ? '0 : W'(g * W'($urandom_range(1, 300))),
                      ($urandom_range(0, 4) == 0) ? '0 : W'(g * W'($urandom_range(1, 300))));
            req[i] = 1'b1;
          end
        end
      end
      serve(int'($urandom_range(0, MW + 2)), bit'($urandom_range(0, 1)));
    end
    for (int i = 0; i < N; i++) if (req != 0) serve(int'($urandom_range(1, MW)), 0);
    set_op(3, 100, 75);
    req = 4'b1000;
    @(negedge clk);
    chk("rst_c1_gnt", gnt, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    rst = 1'b0;
    ptr_m = 0;
    serve(3, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one GCD datapath/control pair among N_REQ requesters. It accepts one operand pair per grant and drives the GCD unit's start/data load sequence: A with start, then B. It waits for done, then returns the result to the granted requester. It also handles zero operands without using the datapath and aborts hung computations with a timeout.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- MAX_WAIT, 1023, max cycles in WAIT before abort (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N_REQ  request per requester, level
- op_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- op_b  in  N_REQ*WIDTH  operand B, same packing
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands accepted
- resp_valid  out  N_REQ  one-hot, one-cycle pulse: result for requester i
- resp_data  out  WIDTH  result, valid with resp_valid
- resp_err  out  1  error flag, valid with resp_valid
- busy  out  1  high in every state except IDLE
- gcd_start  out  1  to GCD unit: start pulse
- gcd_data  out  WIDTH  to GCD unit: data_in
- gcd_done  in  1  from GCD unit
- gcd_result  in  WIDTH  from GCD unit, valid while gcd_done=1

## Operation
- Registered FSM with states IDLE, LOAD_A, LOAD_B, WAIT, RESP.
- All outputs are registered or decoded from the registered state/index only; no input-to-output combinational path.
- Reset (async): state=IDLE, rr pointer=0, and every output is 0 (gnt, resp_valid, resp_data, resp_err, busy, gcd_start, gcd_data). The wait counter is 0.
- IDLE:
  - If req≠0, pick the first set bit searching from pointer upward with wrap.
  - Latch the winner index, op_a and op_b.
  - If both operands are nonzero, go to LOAD_A.
  - Otherwise go to RESP (bypass).
    - Bypass result = the nonzero operand, err=0.
    - gcd(0,0) gives result 0, err=1.
- LOAD_A: gnt[idx]=1, gcd_start=1, gcd_data=A. Go to LOAD_B.
- LOAD_B: gcd_start=0, gcd_data=B. Go to WAIT and clear the counter.
- WAIT:
  - gcd_data holds B; the counter increments every cycle.
  - gcd_done=1: latch gcd_result, err=0, go to RESP.
  - Else if counter == MAX_WAIT-1: result=0, err=1, go to RESP.
  - If gcd_done arrives on the timeout cycle, done wins.
- RESP: resp_valid[idx]=1 with resp_data/resp_err. Bypass responses also pulse gnt[idx] in this cycle. Pointer ← (idx+1) mod N_REQ. Go to IDLE.
- gcd_done outside WAIT is ignored.
- req changes outside IDLE are ignored.
- Counter width is clog2(MAX_WAIT+1).
- resp_data/resp_err hold their last value until the next RESP; only resp_valid qualifies them.

## Timing
- Requester protocol:
  - The requester holds req[i] and its operands stable until gnt[i].
  - req[i] still high in the cycle after RESP is a new request.
- Arbitration happens on the edge that leaves IDLE (cycle c0).
- Normal path:
  - c1 = LOAD_A (gnt pulse, start with A)
  - c2 = LOAD_B (B on gcd_data)
  - c3 onward = WAIT
  - gcd_done sampled high in cycle k means RESP is in cycle k+1.
- Bypass path: c1 = RESP; gnt and resp_valid are both high in c1.
- Timeout: with WAIT entered at c3 and no done, RESP falls in c3+MAX_WAIT.
- Back-to-back: after RESP there is one IDLE cycle, so the minimum spacing between grants is 2 cycles (bypass) or 5 cycles (normal, with done in the first WAIT cycle).
- Reset mid-operation aborts immediately:
  - no resp_valid for the aborted request;
  - the GCD unit shares rst;
  - after release, arbitration restarts with pointer 0.

## Test plan
- Single request, computed path: req[0] with A=36, B=24; GCD model raises done with 12 after 6 WAIT cycles.
  - gnt[0] and gcd_start with gcd_data=36 in c1; gcd_data=24 in c2.
  - resp_valid[0], resp_data=12, resp_err=0 for exactly one cycle; busy falls after RESP.
- Round-robin: req=4'b1111 held, each requester deasserting after its grant.
  - Grants in order 0,1,2,3.
  - Then raise req[0] and req[2] together: req[0] is granted, then req[2].
- Zero bypass, no gcd_start ever pulses:
  - (0,15): resp_data=15, err=0.
  - (9,0): resp_data=9, err=0.
  - (0,0): resp_data=0, err=1.
  - For each, gnt and resp_valid coincide one cycle after arbitration.
- Timeout: MAX_WAIT=8, done never asserted.
  - resp_err=1, resp_data=0, exactly 8 cycles after WAIT entry.
  - A second run with done on the timeout cycle gives err=0 and the model's result.
- Async reset mid-WAIT:
  - All outputs are 0 before the next clock edge, with no resp_valid.
  - req[3] held through reset is granted after release.
- Spurious done: gcd_done pulses in IDLE and LOAD_B are ignored; the response follows only the done seen in WAIT.
